regfile_mp: RTL and testbench

- Parametrised multi-port integer register file, successor to the single-write/dual-read core register file.
- Adds configurable width, depth, read and write port counts, and optional write-to-read bypass.
- Adds a per-register busy scoreboard for the issue stage.
- Adds a sequential post-reset clear sequencer, so the array needs no wide reset fan-out.
- Sits between decode/issue (reads, allocation) and writeback (writes) in the core pipeline.

---
 rtl/regfile_mp.sv | 157 +++++++++++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass, per-register
// busy scoreboard and a sequential post-reset clear of the array.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 init_done
);

  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two and at least 2");
  end
  if (AW != $clog2(NREGS)) begin : g_bad_aw
    $error("regfile_mp: AW is derived from NREGS and must not be overridden");
  end
  if ((XLEN < 1) || (NRD < 1) || (NWR < 1)) begin : g_bad_ports
    $error("regfile_mp: XLEN, NRD and NWR must all be at least 1");
  end

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_reg;
  logic [AW-1:0]     clr_idx_reg;
  logic              init_done_reg;
  logic [NREGS-1:0]  busy_reg;
  logic [NREGS-1:0]  busy_next;
  logic [XLEN-1:0]   regs [NREGS];

  logic              ready;
  logic [NREGS-1:0]  wr_hit;
  logic [XLEN-1:0]   wr_hit_data [NREGS];

  assign ready     = (state_reg == ST_READY);
  assign init_done = init_done_reg;

  // Per-register write decode; scanning ports upward lets the highest index win.
  // The same decode feeds the array update, the bypass and the scoreboard clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign wr_hit[gi]      = 1'b0;
        assign wr_hit_data[gi] = '0;
        assign busy_next[gi]   = 1'b0;
      end else begin : g_live
        logic            hit;
        logic [XLEN-1:0] hit_data;
        logic            alloc_hit;

        always_comb begin
          hit      = 1'b0;
          hit_data = '0;
          if (ready) begin
            for (int p = 0; p < NWR; p++) begin
              if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(gi))) begin
                hit      = 1'b1;
                hit_data = wr_data[p*XLEN +: XLEN];
              end
            end
          end
        end

        assign alloc_hit = ready && alloc_en && (alloc_addr == AW'(gi));

        // A same-cycle allocation means a newer producer, so it beats the clear.
        assign busy_next[gi]   = alloc_hit ? 1'b1 : (hit ? 1'b0 : busy_reg[gi]);
        assign wr_hit[gi]      = hit;
        assign wr_hit_data[gi] = hit_data;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      clr_idx_reg   <= '0;
      init_done_reg <= 1'b0;
      busy_reg      <= '0;
    end else begin
      busy_reg <= busy_next;
      case (state_reg)
        ST_INIT: begin
          clr_idx_reg <= clr_idx_reg + AW'(1);
          if (clr_idx_reg == AW'(NREGS - 1)) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

  // The array has no reset; the clear sequencer zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!ready) begin
        regs[clr_idx_reg] <= '0;
      end else begin
        for (int r = 1; r < NREGS; r++) begin
          if (wr_hit[r]) begin
            regs[r] <= wr_hit_data[r];
          end
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr = rd_addr[gi*AW +: AW];

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (ready && (addr != '0)) begin
          if ((BYPASS != 0) && wr_hit[addr]) begin
            data = wr_hit_data[addr];
          end else begin
            data = regs[addr];
            busy = busy_reg[addr];
          end
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = data;
      assign rd_busy[gi]              = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default (bypass), no-bypass and a small
// 32-bit/16-entry/3-read/1-write variant driven from one clock.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]   rd_addr;
  logic [127:0] a_rd_data, b_rd_data;
  logic [1:0]   a_rd_busy, b_rd_busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         alloc_en;
  logic [4:0]   alloc_addr;
  logic         a_init_done, b_init_done;

  logic [11:0]  c_rd_addr;
  logic [95:0]  c_rd_data;
  logic [2:0]   c_rd_busy;
  logic [0:0]   c_wr_en;
  logic [3:0]   c_wr_addr;
  logic [31:0]  c_wr_data;
  logic         c_alloc_en;
  logic [3:0]   c_alloc_addr;
  logic         c_init_done;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .init_done(a_init_done)
  );

  regfile_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .init_done(b_init_done)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1)) u_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .alloc_en(c_alloc_en),
    .alloc_addr(c_alloc_addr), .init_done(c_init_done)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        al;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
    logic [1:0]  e_busy;
    logic [63:0] e_nb_d1;
    logic [1:0]  e_nb_busy;
  } vec_t;

  localparam logic [63:0] CV = 64'h1234_5678_9ABC_DEF0;
  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(r), 5'(r)};
      @(negedge clk);
      check($sformatf("%s r%0d data0", tag, r), a_rd_data[63:0], 64'd0);
      check($sformatf("%s r%0d data1", tag, r), a_rd_data[127:64], 64'd0);
      check($sformatf("%s r%0d busy", tag, r), {62'd0, a_rd_busy}, 64'd0);
      step();
    end
  endtask

  task automatic wait_init(input string tag, input bit with_c);
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("%s init_done cyc%0d", tag, i), {63'd0, a_init_done}, {63'd0, (i == 32)});
      if (with_c)
        check($sformatf("%s c_init_done cyc%0d", tag, i), {63'd0, c_init_done}, {63'd0, (i >= 16)});
      if (i == 5) begin
        check($sformatf("%s INIT read r5", tag), a_rd_data[63:0], 64'd0);
        check($sformatf("%s INIT busy", tag), {62'd0, a_rd_busy}, 64'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we     wa0   wd0       wa1   wd1      al    aa    ra0   ra1   e_d0      e_d1      busy   nb_d1     nb_busy
    vecs[0]  = '{2'b01, 5'd3, CV,      5'd0, 64'h0,   1'b0, 5'd0, 5'd0, 5'd3, 64'h0,    CV,       2'b00, 64'h0,    2'b00};
    vecs[1]  = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b0, 5'd0, 5'd3, 5'd3, CV,       CV,       2'b00, CV,       2'b00};
    vecs[2]  = '{2'b11, 5'd7, 64'h11,  5'd7, 64'h22,  1'b0, 5'd0, 5'd3, 5'd7, CV,       64'h22,   2'b00, 64'h0,    2'b00};
    vecs[3]  = '{2'b01, 5'd0, 64'hFF,  5'd0, 64'h0,   1'b0, 5'd0, 5'd7, 5'd0, 64'h22,   64'h0,    2'b00, 64'h0,    2'b00};
    vecs[4]  = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b1, 5'd9, 5'd9, 5'd7, 64'h0,    64'h22,   2'b00, 64'h22,   2'b00};
    vecs[5]  = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9, 64'h0,    64'h0,    2'b11, 64'h0,    2'b11};
    vecs[6]  = '{2'b10, 5'd0, 64'h0,   5'd9, 64'h99,  1'b0, 5'd0, 5'd9, 5'd9, 64'h99,   64'h99,   2'b00, 64'h0,    2'b11};
    vecs[7]  = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9, 64'h99,   64'h99,   2'b00, 64'h99,   2'b00};
    vecs[8]  = '{2'b01, 5'd9, 64'hA5,  5'd0, 64'h0,   1'b1, 5'd9, 5'd9, 5'd9, 64'hA5,   64'hA5,   2'b00, 64'h99,   2'b00};
    vecs[9]  = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b1, 5'd0, 5'd9, 5'd0, 64'hA5,   64'h0,    2'b01, 64'h0,    2'b01};
    vecs[10] = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b0, 5'd0, 5'd0, 5'd9, 64'h0,    64'hA5,   2'b10, 64'hA5,   2'b10};
    vecs[11] = '{2'b01, 5'd4, 64'h55,  5'd0, 64'h0,   1'b1, 5'd4, 5'd4, 5'd9, 64'h55,   64'hA5,   2'b10, 64'hA5,   2'b10};
    vecs[12] = '{2'b00, 5'd0, 64'h0,   5'd0, 64'h0,   1'b0, 5'd0, 5'd4, 5'd4, 64'h55,   64'h55,   2'b11, 64'h55,   2'b11};

    idle();
    rd_addr = '0;
    c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_alloc_en = 1'b0; c_alloc_addr = '0;
    rst_n = 1'b0;
    step();
    step();
    check("reset init_done", {63'd0, a_init_done}, 64'd0);
    check("reset c_init_done", {63'd0, c_init_done}, 64'd0);

    // Writes and allocations during INIT must be ignored.
    rst_n = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'd0, 64'hAA};
    alloc_en = 1'b1; alloc_addr = 5'd5;
    rd_addr = {5'd5, 5'd5};
    wait_init("boot", 1'b1);
    idle();
    check("boot b_init_done", {63'd0, b_init_done}, 64'd1);
    read_all("boot");

    for (int v = 0; v < NVEC; v++) begin
      wr_en = vecs[v].we;
      wr_addr = {vecs[v].wa1, vecs[v].wa0};
      wr_data = {vecs[v].wd1, vecs[v].wd0};
      alloc_en = vecs[v].al;
      alloc_addr = vecs[v].aa;
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      @(negedge clk);
      check($sformatf("vec%0d a_data0", v), a_rd_data[63:0], vecs[v].e_d0);
      check($sformatf("vec%0d a_data1", v), a_rd_data[127:64], vecs[v].e_d1);
      check($sformatf("vec%0d a_busy", v), {62'd0, a_rd_busy}, {62'd0, vecs[v].e_busy});
      check($sformatf("vec%0d nb_data1", v), b_rd_data[127:64], vecs[v].e_nb_d1);
      check($sformatf("vec%0d nb_busy", v), {62'd0, b_rd_busy}, {62'd0, vecs[v].e_nb_busy});
      step();
    end
    idle();

    // Reset from READY with r4 holding data and busy, then a second reset mid-INIT.
    rst_n = 1'b0;
    rd_addr = {5'd4, 5'd4};
    step();
    rst_n = 1'b1;
    check("rst1 init_done", {63'd0, a_init_done}, 64'd0);
    check("rst1 INIT read r4", a_rd_data[63:0], 64'd0);
    check("rst1 busy", {62'd0, a_rd_busy}, 64'd0);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2 init_done", {63'd0, a_init_done}, 64'd0);
    wait_init("rst2", 1'b0);
    read_all("rst2");

    // Narrow variant: 3 read ports, one write port, top-entry wrap.
    c_wr_en = 1'b1; c_wr_addr = 4'd1; c_wr_data = 32'h1111_0001;
    step();
    c_wr_addr = 4'd15; c_wr_data = 32'hF0F0_000F;
    step();
    c_wr_en = 1'b0;
    c_rd_addr = {4'd0, 4'd15, 4'd1};
    @(negedge clk);
    check("c set1 p0", {32'd0, c_rd_data[31:0]}, 64'h1111_0001);
    check("c set1 p1", {32'd0, c_rd_data[63:32]}, 64'hF0F0_000F);
    check("c set1 p2", {32'd0, c_rd_data[95:64]}, 64'd0);
    step();
    c_rd_addr = {4'd1, 4'd0, 4'd15};
    @(negedge clk);
    check("c set2 p0", {32'd0, c_rd_data[31:0]}, 64'hF0F0_000F);
    check("c set2 p1", {32'd0, c_rd_data[63:32]}, 64'd0);
    check("c set2 p2", {32'd0, c_rd_data[95:64]}, 64'h1111_0001);
    step();
    c_wr_en = 1'b1; c_wr_addr = 4'd15; c_wr_data = 32'hDEAD_BEEF;
    c_rd_addr = {4'd15, 4'd0, 4'd15};
    @(negedge clk);
    check("c byp p0", {32'd0, c_rd_data[31:0]}, 64'hDEAD_BEEF);
    check("c byp r0 p1", {32'd0, c_rd_data[63:32]}, 64'd0);
    check("c byp p2", {32'd0, c_rd_data[95:64]}, 64'hDEAD_BEEF);
    step();
    c_wr_en = 1'b0;
    c_alloc_en = 1'b1; c_alloc_addr = 4'd15;
    c_rd_addr = {4'd0, 4'd15, 4'd0};
    @(negedge clk);
    check("c wrap r0 p0", {32'd0, c_rd_data[31:0]}, 64'd0);
    check("c wrap p1", {32'd0, c_rd_data[63:32]}, 64'hDEAD_BEEF);
    check("c busy pre", {61'd0, c_rd_busy}, 64'd0);
    step();
    c_alloc_en = 1'b0;
    @(negedge clk);
    check("c busy post", {61'd0, c_rd_busy}, 64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
